// File: rtl/mod_counter_prog.sv
// mod_counter_prog
// Runtime-programmable modulo counter for the lab board LED bank.
// Counts up or down through 0..M-1, where M = mod_val (mod_val = 0 selects
// M = 2^WIDTH). Supports synchronous load, count enable, a terminal-count
// pulse and a divided output in duty (~50%) or toggle mode.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-low; clears count, tc, div_out
//   en        in   count enable
//   up        in   1 = count up, 0 = count down
//   load      in   synchronous load, priority over en
//   load_val  in   value to load (clamped to M-1)
//   mod_val   in   modulus, 0 means 2^WIDTH
//   mode      in   div_out mode: 0 = duty, 1 = toggle
//   count     out  current count (registered)
//   tc        out  one-cycle pulse on each wrap (registered)
//   div_out   out  divided output (registered)
module mod_counter_prog #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] mod_val,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             div_out
);

  logic [WIDTH-1:0] m_max;     // M-1, the top of the legal range
  logic [WIDTH-1:0] m_half;    // M>>1, duty-mode threshold
  logic [WIDTH-1:0] count_nxt;
  logic             wrap;
  logic             div_nxt;

  // mod_val = 0 stands for 2^WIDTH, which does not fit in WIDTH bits, so
  // M-1 and M>>1 are formed directly instead of from a widened M.
  always_comb begin
    if (mod_val == '0) begin
      m_max  = '1;
      m_half = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      m_max  = mod_val - WIDTH'(1);
      m_half = mod_val >> 1;
    end
  end

  always_comb begin
    count_nxt = count;
    wrap      = 1'b0;
    div_nxt   = div_out;

    if (load) begin
      count_nxt = (load_val > m_max) ? m_max : load_val;
      div_nxt   = mode ? div_out : (count_nxt < m_half);
    end else if (en) begin
      if (up) begin
        // ">=" also pulls an out-of-range count (after mod_val shrank) back to 0.
        if (count >= m_max) begin
          count_nxt = '0;
          wrap      = 1'b1;
        end else begin
          count_nxt = count + WIDTH'(1);
        end
      end else begin
        if (count == '0) begin
          count_nxt = m_max;
          wrap      = 1'b1;
        end else if (count > m_max) begin
          // Out of range after a shrink: re-enter at the top, not a wrap.
          count_nxt = m_max;
        end else begin
          count_nxt = count - WIDTH'(1);
        end
      end
      div_nxt = mode ? (div_out ^ wrap) : (count_nxt < m_half);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      tc      <= 1'b0;
      div_out <= 1'b0;
    end else begin
      count   <= count_nxt;
      tc      <= wrap;
      div_out <= div_nxt;
    end
  end

endmodule

// File: tb/tb_mod_counter_prog.sv
// Testbench for mod_counter_prog (WIDTH = 4): directed vector table,
// hand-written corner sequences and randomized stimulus against a
// behavioural model.
module tb_mod_counter_prog;

  localparam int W = 4;
  localparam int FULL = 1 << W;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic         up = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] mod_val = '0;
  logic         mode = 1'b0;
  logic [W-1:0] count;
  logic         tc;
  logic         div_out;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int m_count = 0;
  bit m_tc = 0;
  bit m_div = 0;

  mod_counter_prog #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .mod_val(mod_val), .mode(mode),
    .count(count), .tc(tc), .div_out(div_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       ld;
    bit       e;
    bit       u;
    int       lv;
    int       mv;
    bit       md;
    int       exp_count;
    bit       exp_tc;
    bit       exp_div;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model written from the behavioural rules with plain integers.
  task automatic model_step(input bit ld, input bit e, input bit u,
                            input int lv, input int mv, input bit md);
    int m;
    bit w;
    m = (mv == 0) ? FULL : mv;
    w = 0;
    if (ld) begin
      m_count = (lv < m - 1) ? lv : m - 1;
      if (!md) m_div = (m_count < m / 2);
      m_tc = 0;
    end else if (e) begin
      if (u) begin
        if (m_count >= m - 1) begin m_count = 0; w = 1; end
        else m_count = m_count + 1;
      end else begin
        if (m_count == 0) begin m_count = m - 1; w = 1; end
        else if (m_count > m - 1) m_count = m - 1;
        else m_count = m_count - 1;
      end
      m_tc = w;
      m_div = md ? (m_div ^ w) : (m_count < m / 2);
    end else begin
      m_tc = 0;
    end
  endtask

  task automatic drive(input bit ld, input bit e, input bit u,
                       input int lv, input int mv, input bit md);
    load = ld; en = e; up = u;
    load_val = W'(lv); mod_val = W'(mv); mode = md;
  endtask

  // Apply current inputs across one rising edge, sample 1 ns later.
  task automatic cycle();
    @(posedge clk);
    #1;
    model_step(load, en, up, int'(load_val), int'(mod_val), mode);
  endtask

  task automatic add(input bit ld, input bit e, input bit u, input int lv,
                     input int mv, input bit md, input int ec, input bit et,
                     input bit ed);
    vec_t v;
    v.ld = ld; v.e = e; v.u = u; v.lv = lv; v.mv = mv; v.md = md;
    v.exp_count = ec; v.exp_tc = et; v.exp_div = ed;
    vecs.push_back(v);
  endtask

  initial begin
    // up count, M=5, duty
    add(0,1,1,0,5,0, 1,0,1);
    add(0,1,1,0,5,0, 2,0,0);
    add(0,1,1,0,5,0, 3,0,0);
    add(0,1,1,0,5,0, 4,0,0);
    add(0,1,1,0,5,0, 0,1,1);
    add(0,1,1,0,5,0, 1,0,1);
    // load 0, toggle mode: div holds
    add(1,0,0,0,6,1, 0,0,1);
    // down count, M=6, toggle
    add(0,1,0,0,6,1, 5,1,0);
    add(0,1,0,0,6,1, 4,0,0);
    add(0,1,0,0,6,1, 3,0,0);
    add(0,1,0,0,6,1, 2,0,0);
    add(0,1,0,0,6,1, 1,0,0);
    add(0,1,0,0,6,1, 0,0,0);
    add(0,1,0,0,6,1, 5,1,1);
    // load clamp, and load beating a wrap condition
    add(1,1,1,9,6,1, 5,0,1);
    add(1,1,1,9,6,1, 5,0,1);
    // hold, both modes
    add(0,0,1,0,6,1, 5,0,1);
    add(0,0,1,0,6,0, 5,0,1);
    // M=1
    add(0,1,1,0,1,0, 0,1,0);
    add(0,1,1,0,1,0, 0,1,0);
    add(0,1,0,0,1,0, 0,1,0);
    add(0,0,0,0,1,0, 0,0,0);
    // full range
    add(1,0,1,14,0,0, 14,0,0);
    add(0,1,1,0,0,0, 15,0,0);
    add(0,1,1,0,0,0, 0,1,1);
    add(0,1,1,0,0,0, 1,0,1);
    // mode switching
    add(0,1,1,0,5,0, 2,0,0);
    add(0,1,1,0,5,1, 3,0,0);
    add(0,1,1,0,5,1, 4,0,0);
    add(0,1,1,0,5,1, 0,1,1);
    add(0,1,1,0,5,0, 1,0,1);

    // reset
    reset = 1'b0;
    #23;
    check("reset_count", int'(count), 0);
    check("reset_tc", int'(tc), 0);
    check("reset_div", int'(div_out), 0);
    reset = 1'b1;
    m_count = 0; m_tc = 0; m_div = 0;
    @(posedge clk); #1;

    // vector table
    foreach (vecs[i]) begin
      drive(vecs[i].ld, vecs[i].e, vecs[i].u, vecs[i].lv, vecs[i].mv, vecs[i].md);
      cycle();
      check($sformatf("vec%0d_count", i), int'(count), vecs[i].exp_count);
      check($sformatf("vec%0d_tc", i), int'(tc), int'(vecs[i].exp_tc));
      check($sformatf("vec%0d_div", i), int'(div_out), int'(vecs[i].exp_div));
    end

    // modulus shrink, up
    drive(1,0,1,12,0,0); cycle();
    check("shrink_pre_count", int'(count), 12);
    drive(0,1,1,0,7,0); cycle();
    check("shrink_up_count", int'(count), 0);
    check("shrink_up_tc", int'(tc), 1);
    // modulus shrink, down
    drive(1,0,0,12,0,0); cycle();
    drive(0,1,0,0,7,0); cycle();
    check("shrink_dn_count", int'(count), 6);
    check("shrink_dn_tc", int'(tc), 0);

    // asynchronous reset mid-count
    drive(1,0,1,3,0,0); cycle();
    check("pre_rst_count", int'(count), 3);
    check("pre_rst_div", int'(div_out), 1);
    drive(0,1,1,0,0,0);
    #2 reset = 1'b0;
    #1;
    check("async_rst_count", int'(count), 0);
    check("async_rst_tc", int'(tc), 0);
    check("async_rst_div", int'(div_out), 0);
    @(posedge clk); #3;
    reset = 1'b1;
    m_count = 0; m_tc = 0; m_div = 0;
    check("rst_release_count", int'(count), 0);
    cycle();
    check("resume_count", int'(count), 1);
    check("resume_tc", int'(tc), 0);

    // randomized run against the model
    for (int n = 0; n < 3000; n++) begin
      bit ld;
      int mv;
      ld = ($urandom_range(0, 15) == 0);
      mv = ($urandom_range(0, 7) == 0) ? $urandom_range(0, FULL - 1) : int'(mod_val);
      drive(ld, ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0),
            $urandom_range(0, FULL - 1), mv, ($urandom_range(0, 31) == 0) ? ~mode : mode);
      cycle();
      check("rand_count", int'(count), m_count);
      check("rand_tc", int'(tc), int'(m_tc));
      check("rand_div", int'(div_out), int'(m_div));
      if (errors > 20) break;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_counter_prog.md
Name: mod_counter_prog

Overview:
- Parametrised, runtime-programmable successor to the fixed 3-bit ripple counter and modulo divider on the lab board.
- One synchronous counter with:
  - a modulus selectable at runtime;
  - up/down direction;
  - count enable;
  - synchronous load;
  - a terminal-count pulse;
  - a divided output with two modes: duty (about 50%) or toggle.
- Sits between the debounced button/switch inputs and the LED bank; count, tc and div_out drive LEDs directly.

Parameters:
- WIDTH, 4, counter and modulus width in bits (2..16).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low. reset=0 clears all state immediately, independent of clk.
- en  input  1  count enable; the counter steps on each rising clk while en=1.
- up  input  1  direction: 1 counts up, 0 counts down.
- load  input  1  synchronous load; takes priority over en.
- load_val  input  WIDTH  value applied when load=1.
- mod_val  input  WIDTH  modulus M. 0 means 2^WIDTH; 1 means degenerate single-state counting.
- mode  input  1  div_out mode: 0 = duty, 1 = toggle.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered.
- div_out  output  1  divided clock-enable-style output, registered.

Behaviour:
- Reset: while reset=0, count=0, tc=0, div_out=0. Release takes effect at the first following rising clk.
- Effective modulus: M = mod_val, or 2^WIDTH when mod_val=0. Legal count range is 0..M-1.
- Priority at each rising edge: load > en > hold.
- Load:
  - count <= min(load_val, M-1); tc <= 0.
  - In toggle mode div_out holds; in duty mode div_out is recomputed from the new count.
- Hold (en=0, load=0): count and div_out hold; tc <= 0.
- Up step (en=1, up=1):
  - If count >= M-1: count <= 0 and a wrap occurs. This also covers count left out of range after mod_val shrank.
  - Otherwise count <= count+1.
- Down step (en=1, up=0):
  - If count = 0: count <= M-1 and a wrap occurs.
  - If count > M-1 (out of range): count <= M-1, no wrap.
  - Otherwise count <= count-1.
- M=1: count stays 0 and every enabled step is a wrap.
- tc: set to 1 on the edge where a wrap occurs, 0 on every other edge. It is exactly a one-cycle pulse per wrap, or continuously high if wrapping every cycle.
- div_out, mode 0 (duty): div_out <= (next count < (M>>1)). Examples:
  - M=5: high for counts 0,1 (2 of 5 cycles).
  - M=1: always 0.
  - M=2^WIDTH: high for the lower half of the range.
- div_out, mode 1 (toggle): div_out toggles on each wrap edge, giving period 2*M enabled cycles.
- Switching mode: takes effect at the next edge, with no extra toggle.
- mod_val changes mid-count: take effect at the next edge using the rules above. No glitch or illegal count appears for more than one enabled cycle.
- Direction reversal: tc and wrap are evaluated using the up value sampled at that edge.
- Simultaneous load and wrap condition: load wins and tc=0.
- All outputs are driven only by flops; no combinational path from inputs to outputs.

Test Plan:
- Reset: drive reset=0 mid-count (count=3) asynchronously between clk edges -> count=0, tc=0, div_out=0 immediately. After release the count resumes from 0.
- Up count, M=5, mode 0, en=1:
  - count sequence 0,1,2,3,4,0,1…;
  - tc=1 only in the cycle count shows 0 after 4;
  - div_out high for counts 0,1.
- Down count, M=6, mode 1:
  - sequence 0,5,4,3,2,1,0,5…;
  - tc pulses on each 0->5 edge;
  - div_out toggles each wrap (period 12 cycles).
- Load: load=1 with load_val=9, M=6 -> count=5, tc=0. Same cycle with en=1, up=1 -> load still wins.
- Modulus shrink: count=12, WIDTH=4, mod_val changed 0->7 with up=1 -> next edge count=0, tc=1. Same with up=0 -> count=6, tc=0.
- Degenerate and full range:
  - mod_val=1 -> count stays 0, tc continuously 1 while en=1;
  - mod_val=0 -> counts 0..15 with tc on the 15->0 edge;
  - en=0 -> all outputs hold and tc=0.
